// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage sitting directly in front of decode. Holds the
// program counter, fetches one instruction per step from instruction memory
// using a simple ready handshake, presents it to decode, and on acknowledge
// computes the next PC and bumps the retired-instruction count.
//
// Sequence per instruction: BOOT (after reset only) -> FETCH -> EXEC -> FETCH.
// With zero-wait memory this gives one instruction every two cycles.
//
// Optional feature (compile-time macro PC_ALIGN_CHECK_EN):
//   defined   : a selected next-PC target with nonzero [1:0] sets the sticky
//               misalign_err flag, and the PC loads the target with [1:0]
//               cleared.
//   undefined : misalign_err is tied low and the PC loads the target as is.
//
// Parameters:
//   ADDR_WIDTH  PC / memory address width (must be >= 28 for the jump form)
//   DATA_WIDTH  instruction width
//   RESET_PC    PC value loaded on reset
//   PC_STEP     sequential PC increment
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   pc_sel        next-PC select: 0 seq, 1 cond branch, 2 jump, 3 register,
//                 4 branch-if-negative, 5..7 seq
//   beq, bne      branch qualifiers (only looked at when pc_sel == 1)
//   zero, neg     ALU flags (zero used for pc_sel 1, neg for pc_sel 4)
//   branch_imm    signed word offset for branches
//   jump_target   word target for jumps
//   rs_data       register target for pc_sel 3
//   instr_ack     core has executed the presented instruction
//   imem_req      fetch request (high throughout FETCH)
//   imem_addr     fetch address, equals the PC
//   imem_rdata    fetched instruction, valid when imem_ready is high
//   imem_ready    memory data valid this cycle
//   instr_out     instruction presented to decode
//   instr_valid   instr_out is valid (high throughout EXEC)
//   pc_out        PC of the presented instruction
//   retired       retired-instruction count, wraps at 2^32
//   misalign_err  sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            pc_sel,
    input  logic                  beq,
    input  logic                  bne,
    input  logic                  zero,
    input  logic                  neg,
    input  logic [15:0]           branch_imm,
    input  logic [25:0]           jump_target,
    input  logic [ADDR_WIDTH-1:0] rs_data,
    input  logic                  instr_ack,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  imem_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [31:0]           retired,
    output logic                  misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   pc_out_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [31:0]             retired_q;

    logic [ADDR_WIDTH-1:0]   pc4;
    logic [ADDR_WIDTH-1:0]   br_off;
    logic [ADDR_WIDTH-1:0]   btgt;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   next_pc;

    logic                    fetch_done;
    logic                    exec_done;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking (<=) assignments so all
    // registers update together from pre-edge values; blocking (=) here would
    // create order-dependent simulation and sim/synth mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default before the case; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_done  = 1'b0;
        exec_done   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    fetch_done = 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    exec_done = 1'b1;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-PC selection. Qualifiers are only evaluated inside the branch arm
    // that uses them, so unknowns on unrelated inputs cannot leak into the
    // result.
    // -------------------------------------------------------------------------
    always_comb begin
        pc4    = pc_q + ADDR_WIDTH'(PC_STEP);
        br_off = {{(ADDR_WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
        btgt   = pc4 + br_off;
        target = pc4;
        case (pc_sel)
            3'd1: begin
                if ((beq & zero) | (bne & ~zero)) begin
                    target = btgt;
                end
            end
            3'd2: begin
                // Keep the upper region bits of pc4, replace the low 28 bits.
                target[27:0] = {jump_target, 2'b00};
            end
            3'd3: begin
                target = rs_data;
            end
            3'd4: begin
                if (neg) begin
                    target = btgt;
                end
            end
            default: begin
                target = pc4;
            end
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q;

    assign next_pc = {target[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (exec_done && (target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign next_pc      = target;
    assign misalign_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pc_out_q  <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            if (fetch_done) begin
                instr_q  <= imem_rdata;
                pc_out_q <= pc_q;
            end
            if (exec_done) begin
                pc_q      <= next_pc;
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_out_q;
    assign instr_out = instr_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit with default parameters. Inputs are
// driven and outputs sampled on the falling clock edge. Directed vectors come
// from a table of {start PC, controls, expected next PC}; randomized
// instructions are checked against an arithmetic next-PC model. Honours
// PC_ALIGN_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  pc_sel;
    logic        beq, bne, zero, neg;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;
    logic [31:0] rs_data;
    logic        instr_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] retired;
    logic        misalign_err;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_sel       (pc_sel),
        .beq          (beq),
        .bne          (bne),
        .zero         (zero),
        .neg          (neg),
        .branch_imm   (branch_imm),
        .jump_target  (jump_target),
        .rs_data      (rs_data),
        .instr_ack    (instr_ack),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .pc_out       (pc_out),
        .retired      (retired),
        .misalign_err (misalign_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_err;

    typedef struct {
        logic [31:0] start;
        logic [2:0]  sel;
        logic        b_eq;
        logic        b_ne;
        logic        z;
        logic        n;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next PC straight from the selection rules, in plain 32-bit arithmetic.
    function automatic logic [31:0] model_next(
        input logic [31:0] pc, input logic [2:0] sel,
        input logic b_eq, input logic b_ne, input logic z, input logic n,
        input logic [15:0] imm, input logic [25:0] jt, input logic [31:0] rs,
        output logic mis);
        logic [31:0] seq, br, t;
        seq = pc + 32'd4;
        br  = seq + 32'(int'($signed(imm)) * 4);
        case (sel)
            3'd1:    t = ((b_eq && z) || (b_ne && !z)) ? br : seq;
            3'd2:    t = (seq & 32'hF000_0000) + 32'(jt) * 32'd4;
            3'd3:    t = rs;
            3'd4:    t = n ? br : seq;
            default: t = seq;
        endcase
        mis = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        mis = (t % 4) != 0;
        t   = t - (t % 4);
`endif
        return t;
    endfunction

    task automatic model_reset();
        m_pc  = 32'h0;
        m_ret = 32'h0;
        m_err = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},     64'(imem_req),     64'h0);
        check({tag, "_valid"},   64'(instr_valid),  64'h0);
        check({tag, "_instr"},   64'(instr_out),    64'h0);
        check({tag, "_pc_out"},  64'(pc_out),       64'h0);
        check({tag, "_addr"},    64'(imem_addr),    64'h0);
        check({tag, "_retired"}, 64'(retired),      64'h0);
        check({tag, "_misalign"},64'(misalign_err), 64'h0);
    endtask

    // Waits (bounded) until the DUT is requesting a fetch.
    task automatic wait_fetch();
        int k;
        k = 0;
        while (imem_req !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (imem_req !== 1'b1) check("fetch_timeout", 64'(imem_req), 64'h1);
    endtask

    // One full fetch/execute step. 'waits' adds memory wait states (with a
    // stray ack on the first one) and an idle EXEC cycle with a stray ready.
    task automatic run_instr(input logic [2:0] sel, input logic b_eq, input logic b_ne,
                             input logic z, input logic n, input logic [15:0] imm,
                             input logic [25:0] jt, input logic [31:0] rs, input int waits);
        logic [31:0] word;
        logic        mis;
        wait_fetch();
        check("fetch_addr", 64'(imem_addr), 64'(m_pc));
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            instr_ack  = (i == 0);
            @(negedge clk);
            instr_ack = 1'b0;
            check("wait_req",  64'(imem_req),  64'h1);
            check("wait_addr", 64'(imem_addr), 64'(m_pc));
        end
        word       = $urandom;
        imem_rdata = word;
        imem_ready = 1'b1;
        @(negedge clk);
        check("exec_valid",  64'(instr_valid), 64'h1);
        check("exec_req",    64'(imem_req),    64'h0);
        check("exec_instr",  64'(instr_out),   64'(word));
        check("exec_pc_out", 64'(pc_out),      64'(m_pc));
        if (waits > 0) begin
            imem_rdata = ~word;
            @(negedge clk);
            check("stray_ready_instr", 64'(instr_out),   64'(word));
            check("stray_ready_valid", 64'(instr_valid), 64'h1);
        end
        imem_ready  = 1'b0;
        pc_sel      = sel;
        beq         = b_eq;
        bne         = b_ne;
        zero        = z;
        neg         = n;
        branch_imm  = imm;
        jump_target = jt;
        rs_data     = rs;
        instr_ack   = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        m_pc  = model_next(m_pc, sel, b_eq, b_ne, z, n, imm, jt, rs, mis);
        m_ret = m_ret + 32'd1;
        m_err = m_err | mis;
        check("after_valid",    64'(instr_valid),  64'h0);
        check("after_req",      64'(imem_req),     64'h1);
        check("after_addr",     64'(imem_addr),    64'(m_pc));
        check("after_retired",  64'(retired),      64'(m_ret));
        check("after_misalign", 64'(misalign_err), 64'(m_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        pc_sel      = 3'd0;
        {beq, bne, zero, neg} = 4'b0;
        branch_imm  = '0;
        jump_target = '0;
        rs_data     = '0;
        instr_ack   = 1'b0;
        imem_rdata  = '0;
        imem_ready  = 1'b0;
        model_reset();

        //               start          sel   beq   bne   z     n     imm       jt        rs     exp
        vecs[0]  = '{32'h10,        3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0,  32'h0, 32'h0C};
        vecs[1]  = '{32'h10,        3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 26'h0,  32'h0, 32'h14};
        vecs[2]  = '{32'h0,         3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    26'h40, 32'h0, 32'h100};
        vecs[3]  = '{32'h100,       3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    26'h0,  32'h204, 32'h204};
        vecs[4]  = '{32'h0,         3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h3,    26'h0,  32'h0, 32'h10};
        vecs[5]  = '{32'h0,         3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3,    26'h0,  32'h0, 32'h4};
        vecs[6]  = '{32'h20,        3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h10,   26'h0,  32'h0, 32'h64};
        vecs[7]  = '{32'h20,        3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h10,   26'h0,  32'h0, 32'h24};
        vecs[8]  = '{32'h20,        3'd1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h10,   26'h0,  32'h0, 32'h24};
        vecs[9]  = '{32'h20,        3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 16'h10,   26'h40, 32'h80, 32'h24};
        vecs[10] = '{32'hFFFFFFFC,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    26'h0,  32'h0, 32'h0};
        vecs[11] = '{32'hF0000010,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0,    26'h40, 32'h0, 32'hF0000100};
        vecs[12] = '{32'hFFFFFFF8,  3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4,    26'h0,  32'h0, 32'h0C};
        vecs[13] = '{32'h40,        3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 26'h0,  32'h0, 32'hFFFE0044};
        vecs[14] = '{32'h20,        3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h10,   26'h40, 32'h80, 32'h24};

        // Reset state and first request one cycle after release
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        #1;
        check("boot_req", 64'(imem_req), 64'h0);
        @(negedge clk);
        check("first_req",  64'(imem_req),  64'h1);
        check("first_addr", 64'(imem_addr), 64'h0);

        // Sequential fetch 0,4,8,12 with zero-wait memory, then wait states
        for (int i = 0; i < 3; i++) run_instr(3'd0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 0);
        check("seq_retired3", 64'(retired), 64'h3);
        check("seq_addr12",   64'(imem_addr), 64'hC);
        run_instr(3'd0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 5);

        // Table-driven next-PC vectors: reach start PC with a register jump
        for (int v = 0; v < 15; v++) begin
            run_instr(3'd3, 0, 0, 0, 0, 16'h0, 26'h0, vecs[v].start, 0);
            run_instr(vecs[v].sel, vecs[v].b_eq, vecs[v].b_ne, vecs[v].z, vecs[v].n,
                      vecs[v].imm, vecs[v].jt, vecs[v].rs, v % 3);
            check($sformatf("vec%0d_next_pc", v), 64'(imem_addr), 64'(vecs[v].exp_pc));
        end

        // Misaligned register target
        run_instr(3'd3, 0, 0, 0, 0, 16'h0, 26'h0, 32'h102, 0);
`ifdef PC_ALIGN_CHECK_EN
        check("misalign_pc",   64'(imem_addr),    64'h100);
        check("misalign_flag", 64'(misalign_err), 64'h1);
`else
        check("misalign_pc",   64'(imem_addr),    64'h102);
        check("misalign_flag", 64'(misalign_err), 64'h0);
`endif

        // Randomized instructions against the model
        for (int r = 0; r < 150; r++) begin
            run_instr(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 16'($urandom), 26'($urandom), $urandom,
                      int'($urandom_range(0, 2)));
        end

        // Reset asserted during a FETCH wait with ready pulsing
        wait_fetch();
        imem_ready = 1'b0;
        @(negedge clk);
        imem_rdata = 32'hDEAD_BEEF;
        imem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_ready = ~imem_ready;
            check("inreset_req",   64'(imem_req),    64'h0);
            check("inreset_valid", 64'(instr_valid), 64'h0);
        end
        imem_ready = 1'b0;
        rst_n      = 1'b1;
        model_reset();
        #1;
        check_reset_values("release");
        @(negedge clk);
        check("refetch_req",  64'(imem_req),  64'h1);
        check("refetch_addr", 64'(imem_addr), 64'h0);
        for (int i = 0; i < 3; i++) run_instr(3'd0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, i);
        check("post_reset_retired", 64'(retired), 64'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
